// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types for the two-requester shared register arbiter.
package shared_reg_arbiter_pkg;

  localparam int HOLD_MAX = 255;
  // Counter only needs to reach HOLD_MAX-1
  localparam int HOLD_W   = $clog2(HOLD_MAX);
  localparam int STATE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  function automatic state_e own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_hold_counter.sv
// Consecutive-write counter for the current owner; clear wins over enable,
// saturates at limit_i and flags reaching it.
module shared_reg_arbiter_hold_counter
  import shared_reg_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [HOLD_W-1:0] limit_i,
  output logic              term_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != limit_i))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter with bounded hold time; sole writer of the shared
// register d on behalf of two requesters.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] d,
  output logic             d_wr,
  output logic             owner
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  state_e                 state_q, state_d;
  logic                   last_q;
  logic [1:0]             req;
  logic [1:0][WIDTH-1:0]  data;
  logic                   own_idx, cur_req, oth_req;
  logic                   wr_en, chg, term;

  assign req     = {req1, req0};
  assign data    = {data1, data0};
  assign own_idx = (state_q == OWN1);
  assign cur_req = req[own_idx];
  assign oth_req = req[~own_idx];

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = own_state(~last_q);
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (cur_req) begin
          wr_en = 1'b1;
          // Hand over right after the last allowed write, no idle gap
          if (oth_req && term) state_d = own_state(~own_idx);
        end else begin
          state_d = oth_req ? own_state(~own_idx) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign chg = (state_d != state_q);

  shared_reg_arbiter_hold_counter u_hold (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (chg),
    .en_i    (wr_en),
    .limit_i (HOLD_LIM),
    .term_o  (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt0    <= (state_d == OWN0);
      gnt1    <= (state_d == OWN1);
      if (chg && (state_d != IDLE)) last_q <= (state_d == OWN1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d     <= '0;
      d_wr  <= 1'b0;
      owner <= 1'b0;
    end else begin
      d_wr <= wr_en;
      if (wr_en) begin
        d     <= data[own_idx];
        owner <= own_idx;
      end
    end
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Arbitrates write access to a single shared output register between two requesters in one clock domain, replacing designs where two processes drive the same register. Each requester presents a request and data word; the block grants one owner at a time with round-robin fairness and a bounded hold time, and is the only writer of the register. Sits between producer logic and any register that more than one source must update.

## Interface

Parameters:
- WIDTH, 1, width of data inputs and of the shared register
- MAX_HOLD, 4, maximum consecutive write cycles one owner keeps the grant while the other requester waits (legal range 1..255)

Ports:
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-low; asserting clears all state immediately, release synchronous to clk by upstream
- req0  input  1  requester 0 wants to write
- data0  input  WIDTH  requester 0 write data
- req1  input  1  requester 1 wants to write
- data1  input  WIDTH  requester 1 write data
- gnt0  output  1  requester 0 owns the register this cycle (registered)
- gnt1  output  1  requester 1 owns the register this cycle (registered)
- d  output  WIDTH  shared register
- d_wr  output  1  one-cycle pulse: d was updated at the preceding edge
- owner  output  1  index of last granted requester (valid when d_wr=1)

## Operation

- FSM states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1); never both high.
- Priority pointer `last`: index of most recent owner; reset value 1 so requester 0 wins the first tie.
- IDLE: only reqX high -> OWNX. Both high -> OWN(~last). Neither -> stay.
- OWNX with reqX high: d <= dataX, d_wr <= 1, owner <= X, hold_cnt increments (saturating at MAX_HOLD-1).
- OWNX with reqX low: no write, d_wr <= 0; next state OWN(~X) if other req high, else IDLE.
- OWNX, reqX high, other req high, hold_cnt == MAX_HOLD-1: this cycle's write completes, next state OWN(~X) directly (no IDLE gap).
- OWNX, reqX high, other req low: stay OWNX indefinitely; hold_cnt saturates.
- Every state change: hold_cnt <= 0, last <= new owner.
- d holds its value whenever no write occurs.

## Timing

- Reset (reset=0, any time, mid-burst included): state IDLE, gnt0=gnt1=0, d=0, d_wr=0, owner=0, hold_cnt=0, last=1. Takes effect without clk.
- Grant latency: req sampled high at edge k in IDLE -> gnt high in cycle k+1.
- Write latency: data sampled at edge ending the first grant cycle; d and d_wr=1 visible one cycle later (2 cycles after req from IDLE).
- Requester must hold data valid while its gnt is high; data with gnt low is ignored.
- Dropping req while granted releases ownership at the next edge; no write in the dropping cycle.
- Contended throughput: owner X gets exactly MAX_HOLD writes, then other owner starts next cycle; d_wr stays high continuously across the handover.
- MAX_HOLD=1: strict alternation under continuous contention.

## Structure

- Package shared_reg_arbiter_pkg: state enum (IDLE, OWN0, OWN1), state width localparam, hold counter width localparam derived from 255 max.
- One sub-module natural: hold_counter (clear, enable, saturate at limit, terminal flag), async active-low reset.
- Top holds FSM, pointer and the single always block writing d.

## Test plan

- Reset mid-burst: req0=1, data0=1 for 3 cycles, assert reset -> all outputs 0 at once; release, req0 -> first grant to 0.
- Single requester: req1=1, data1 alternating 1,0,1 (WIDTH=1) -> gnt1 from cycle 1, d follows data1 two cycles after each sample, d_wr=1 continuous, owner=1.
- Tie from IDLE after reset: req0=req1=1 -> gnt0 first; MAX_HOLD=4 -> 4 writes owner 0, then 4 writes owner 1, alternating, no d_wr gap.
- MAX_HOLD=1, both requesting, data0=0, data1=1 -> d toggles every cycle, gnt0/gnt1 alternate.
- Owner drops: OWN0 for 2 cycles, req0 falls with req1 high -> next cycle gnt1=1, no write in drop cycle (d_wr low one cycle).
- Idle hold: all req low 10 cycles after write of 1 -> d stays 1, d_wr=0, state IDLE, gnt both 0.
